magia_boot_ctrl: RTL and testbench
==================================

MAGIA_BOOT_CTRL -- requirements
Module: magia_boot_ctrl

Interface
REQ-001 SHALL have parameter N_TILES, default 16, number of mesh tiles sequenced.
REQ-002 SHALL have parameter STAGGER_CYCLES, default 4, cycles between successive per-tile fetch enables (0 = all tiles at once).
REQ-003 SHALL have parameter SLEEP_WINDOW, default 16, consecutive all-sleep cycles that declare completion (legal range >= 1).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  input  1  single-cycle pulse that starts a boot sequence.
REQ-007 SHALL have port abort_i  input  1  level input; forces return to IDLE.
REQ-008 SHALL have port boot_addr_i  input  32  boot address; sampled on an accepted start.
REQ-009 SHALL have port timeout_i  input  32  run-cycle limit; 0 disables the limit.
REQ-010 SHALL have port core_sleep_i  input  N_TILES  per-tile core sleep status.
REQ-011 SHALL have port tile_enable_o  output  1  mesh tile enable.
REQ-012 SHALL have port fetch_enable_o  output  N_TILES  per-tile fetch enable.
REQ-013 SHALL have port boot_addr_o  output  32  latched boot address.
REQ-014 SHALL have ports busy_o, done_o, timeout_o  output  1 each  status flags.
REQ-015 SHALL have port run_cycles_o  output  32  cycles spent in STAGGER+RUN, saturating at 2^32-1.

Function
REQ-016 SHALL implement the FSM states IDLE, ENABLE, STAGGER, RUN, DONE, ERROR.
REQ-017 IDLE, DONE and ERROR SHALL accept start_i: latch boot_addr_i, clear the status flags and run_cycles_o, clear the stagger and timeout counters, go to ENABLE next cycle.
REQ-018 start_i SHALL be ignored in ENABLE, STAGGER and RUN.
REQ-019 ENABLE SHALL assert tile_enable_o for exactly 1 cycle with fetch_enable_o all-zero, then go to STAGGER.
REQ-020 tile_enable_o SHALL stay high in ENABLE, STAGGER, RUN and DONE, and be low in IDLE and ERROR.
REQ-021 STAGGER: bit k of fetch_enable_o SHALL set in cycle k*STAGGER_CYCLES after STAGGER entry (bit 0 in the entry cycle); set bits stay set.
REQ-022 STAGGER SHALL go to RUN the cycle after bit N_TILES-1 is set; with STAGGER_CYCLES=0 all bits set in the entry cycle and STAGGER lasts 1 cycle.
REQ-023 RUN: a counter SHALL increment each cycle core_sleep_i is all-ones and clear to 0 on any cycle it is not.
REQ-024 When that counter reaches SLEEP_WINDOW, the FSM SHALL go to DONE.
REQ-025 run_cycles_o SHALL increment every cycle in STAGGER and RUN, and hold in all other states.
REQ-026 If timeout_i != 0 and run_cycles_o reaches timeout_i while in STAGGER or RUN, the FSM SHALL go to ERROR.
REQ-027 If the completion and timeout conditions occur in the same cycle, completion (DONE) SHALL win.
REQ-028 DONE SHALL clear fetch_enable_o and assert done_o; the state holds until start_i or abort_i.
REQ-029 ERROR SHALL clear fetch_enable_o and tile_enable_o and assert timeout_o; the state holds until start_i or abort_i.
REQ-030 busy_o SHALL be 1 in ENABLE, STAGGER and RUN, and 0 otherwise.
REQ-031 abort_i SHALL send the FSM to IDLE next cycle from any state, clearing all outputs except boot_addr_o and run_cycles_o.
REQ-032 abort_i SHALL take priority over start_i, completion and timeout in the same cycle.
REQ-033 All outputs SHALL be registered (no combinational input-to-output path).

Reset
REQ-034 rst_i SHALL be synchronous and active-high, with priority over abort_i and start_i.
REQ-035 On reset the FSM SHALL be in IDLE and every output SHALL be 0 (tile_enable_o, fetch_enable_o, boot_addr_o, busy_o, done_o, timeout_o, run_cycles_o).
REQ-036 Reset asserted mid-sequence SHALL take effect on the next edge, including in STAGGER with partial fetch enables.

Structure
REQ-037 The FSM state enum and the default parameter constants SHALL live in magia_pkg.
REQ-038 One sub-module SHALL be used: magia_sat_counter (parameterised width, clear/enable, saturating), instantiated for run_cycles_o, the stagger counter and the sleep-window counter.

Verification
REQ-039 Nominal boot, N_TILES=4, STAGGER_CYCLES=2, SLEEP_WINDOW=3: start with boot_addr_i=0x1C00_0080 -> ENABLE 1 cycle; fetch_enable_o = 0001, 0011, 0111, 1111 at STAGGER cycles 0, 2, 4, 6; core_sleep_i=1111 for 3 cycles -> done_o=1, fetch_enable_o=0, boot_addr_o=0x1C00_0080.
REQ-040 Sleep glitch: core_sleep_i=1111 for 2 cycles, 0111 for 1 cycle, then 1111 -> DONE only after 3 further all-sleep cycles.
REQ-041 Timeout: timeout_i=20 with cores never sleeping -> timeout_o=1 when run_cycles_o=20, tile_enable_o=0; same-cycle completion case -> done_o=1, timeout_o=0.
REQ-042 Abort in STAGGER with fetch_enable_o=0011 and start_i asserted in the same cycle -> IDLE next cycle with all enables 0; the start is ignored.
REQ-043 Reset during RUN -> next cycle all outputs 0; start_i pulsed in RUN -> no effect; restart from DONE -> flags cleared and run_cycles_o=0.

Source files
------------

// File: rtl/magia_pkg.sv
// Shared types and default constants for the MAGIA mesh boot controller.
package magia_pkg;

   // Boot sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENABLE  = 3'd1,
      ST_STAGGER = 3'd2,
      ST_RUN     = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERROR   = 3'd5
   } boot_state_e;

   // Default parameter values for the controller
   localparam int unsigned DEF_N_TILES        = 16;
   localparam int unsigned DEF_STAGGER_CYCLES = 4;
   localparam int unsigned DEF_SLEEP_WINDOW   = 16;

   // Width of every internal counter; matches the run-cycle output
   localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/magia_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module magia_sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] r_count;

   // Clear beats enable; once all-ones the count holds
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count <= '0;
      end else if (clr_i) begin
         r_count <= '0;
      end else if (en_i && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count_o = r_count;

endmodule

// File: rtl/magia_boot_ctrl.sv
// Mesh boot controller: enables the tile array, staggers per-tile fetch
// enables, then waits for every core to sleep for a window (or times out).
module magia_boot_ctrl
   import magia_pkg::*;
#(
   parameter int unsigned N_TILES        = DEF_N_TILES,
   parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
   parameter int unsigned SLEEP_WINDOW   = DEF_SLEEP_WINDOW
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [31:0]        boot_addr_i,
   input  logic [31:0]        timeout_i,
   input  logic [N_TILES-1:0] core_sleep_i,
   output logic               tile_enable_o,
   output logic [N_TILES-1:0] fetch_enable_o,
   output logic [31:0]        boot_addr_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               timeout_o,
   output logic [31:0]        run_cycles_o
);

   boot_state_e        r_state;
   logic               r_tile_en;
   logic [N_TILES-1:0] r_fetch_en;
   logic [31:0]        r_boot_addr;
   logic               r_busy;
   logic               r_done;
   logic               r_timeout;

   logic [CNT_W-1:0]   w_run_cnt;
   logic [CNT_W-1:0]   w_run_inc;
   logic [CNT_W-1:0]   w_stag_cnt;
   logic [CNT_W-1:0]   w_sleep_cnt;
   logic               w_all_sleep;
   logic               w_in_boot;
   logic               w_start_acc;
   logic               w_timeout_hit;
   logic               w_done_hit;
   logic [N_TILES-1:0] w_first_mask;
   logic [N_TILES-1:0] w_next_mask;

   assign w_all_sleep = &core_sleep_i;
   assign w_in_boot   = (r_state == ST_STAGGER) || (r_state == ST_RUN);
   assign w_start_acc = start_i && !abort_i &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));

   // Run count as it will read after this edge, so timeout fires together
   // with the counter showing the limit
   assign w_run_inc     = (w_run_cnt == '1) ? w_run_cnt : (w_run_cnt + 1'b1);
   assign w_timeout_hit = (timeout_i != '0) && (w_run_inc >= timeout_i);

   // Completion when this all-sleep cycle brings the window count to the target
   assign w_done_hit = (r_state == ST_RUN) && w_all_sleep &&
                       (({1'b0, w_sleep_cnt} + 33'd1) >= 33'(SLEEP_WINDOW));

   // Cycles spent in STAGGER+RUN; cleared by an accepted start
   magia_sat_counter #(.WIDTH(CNT_W)) u_run_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (w_start_acc),
      .en_i    (w_in_boot),
      .count_o (w_run_cnt)
   );

   // Cycle index within STAGGER (0 in the entry cycle)
   magia_sat_counter #(.WIDTH(CNT_W)) u_stag_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (r_state != ST_STAGGER),
      .en_i    (r_state == ST_STAGGER),
      .count_o (w_stag_cnt)
   );

   // Consecutive all-sleep cycles seen in RUN
   magia_sat_counter #(.WIDTH(CNT_W)) u_sleep_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   ((r_state != ST_RUN) || !w_all_sleep),
      .en_i    (w_all_sleep),
      .count_o (w_sleep_cnt)
   );

   // Tile gi turns on at STAGGER cycle gi*STAGGER_CYCLES; masks give the
   // enable set for the entry cycle and for the cycle after the current one
   genvar gi;
   generate
      for (gi = 0; gi < N_TILES; gi++) begin : g_mask
         localparam logic [32:0] OFFSET = 33'(gi) * 33'(STAGGER_CYCLES);
         assign w_first_mask[gi] = (OFFSET == 33'd0);
         assign w_next_mask[gi]  = (({1'b0, w_stag_cnt} + 33'd1) >= OFFSET);
      end
   endgenerate

   // Boot sequencer with all outputs registered alongside the state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_tile_en   <= 1'b0;
         r_fetch_en  <= '0;
         r_boot_addr <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else if (abort_i) begin
         r_state    <= ST_IDLE;
         r_tile_en  <= 1'b0;
         r_fetch_en <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start_i) begin
                  r_state     <= ST_ENABLE;
                  r_boot_addr <= boot_addr_i;
                  r_tile_en   <= 1'b1;
                  r_fetch_en  <= '0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_timeout   <= 1'b0;
               end
            end
            ST_ENABLE: begin
               r_state    <= ST_STAGGER;
               r_fetch_en <= w_first_mask;
            end
            ST_STAGGER: begin
               if (w_timeout_hit) begin
                  r_state    <= ST_ERROR;
                  r_tile_en  <= 1'b0;
                  r_fetch_en <= '0;
                  r_busy     <= 1'b0;
                  r_timeout  <= 1'b1;
               end else if (r_fetch_en[N_TILES-1]) begin
                  r_state <= ST_RUN;
               end else begin
                  r_fetch_en <= w_next_mask;
               end
            end
            ST_RUN: begin
               if (w_done_hit) begin
                  r_state    <= ST_DONE;
                  r_fetch_en <= '0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
               end else if (w_timeout_hit) begin
                  r_state    <= ST_ERROR;
                  r_tile_en  <= 1'b0;
                  r_fetch_en <= '0;
                  r_busy     <= 1'b0;
                  r_timeout  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tile_enable_o  = r_tile_en;
   assign fetch_enable_o = r_fetch_en;
   assign boot_addr_o    = r_boot_addr;
   assign busy_o         = r_busy;
   assign done_o         = r_done;
   assign timeout_o      = r_timeout;
   assign run_cycles_o   = w_run_cnt;

endmodule

// File: tb/tb_magia_boot_ctrl.sv
// Self-checking bench for magia_boot_ctrl (4 tiles, stagger 2, sleep window 3).
module tb_magia_boot_ctrl;

   localparam int NT = 4;
   localparam int SC = 2;
   localparam int SW = 3;

   localparam int P_IDLE = 0;
   localparam int P_EN   = 1;
   localparam int P_STAG = 2;
   localparam int P_RUN  = 3;
   localparam int P_DONE = 4;
   localparam int P_ERR  = 5;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [31:0]   boot_addr_i = '0;
   logic [31:0]   timeout_i = '0;
   logic [NT-1:0] core_sleep_i = '0;
   logic          tile_enable_o;
   logic [NT-1:0] fetch_enable_o;
   logic [31:0]   boot_addr_o;
   logic          busy_o;
   logic          done_o;
   logic          timeout_o;
   logic [31:0]   run_cycles_o;

   always #5 clk_i = ~clk_i;

   magia_boot_ctrl #(
      .N_TILES        (NT),
      .STAGGER_CYCLES (SC),
      .SLEEP_WINDOW   (SW)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .boot_addr_i    (boot_addr_i),
      .timeout_i      (timeout_i),
      .core_sleep_i   (core_sleep_i),
      .tile_enable_o  (tile_enable_o),
      .fetch_enable_o (fetch_enable_o),
      .boot_addr_o    (boot_addr_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .timeout_o      (timeout_o),
      .run_cycles_o   (run_cycles_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Stimulus values applied on the next tick
   logic [31:0]   tb_addr  = '0;
   logic [31:0]   tb_tmo   = '0;
   logic [NT-1:0] tb_sleep = '0;

   // Reference model state
   int          m_phase = P_IDLE;
   int          m_run   = 0;
   int          m_stag  = 0;
   int          m_sleep = 0;
   logic [31:0] m_addr  = '0;

   logic [7:0] w_status;
   assign w_status = {tile_enable_o, busy_o, done_o, timeout_o, fetch_enable_o};

   // Tiles whose turn-on time (k * stagger) has been reached
   function automatic logic [NT-1:0] ref_mask(input int stag);
      logic [NT-1:0] m;
      m = '0;
      for (int k = 0; k < NT; k++) begin
         if (k * SC <= stag) m[k] = 1'b1;
      end
      return m;
   endfunction

   // Expected {tile, busy, done, timeout, fetch} for the model's phase
   function automatic logic [7:0] exp_status();
      logic          t, b, d, e;
      logic [NT-1:0] f;
      t = (m_phase >= P_EN) && (m_phase <= P_DONE);
      b = (m_phase >= P_EN) && (m_phase <= P_RUN);
      d = (m_phase == P_DONE);
      e = (m_phase == P_ERR);
      f = (m_phase == P_STAG) ? ref_mask(m_stag) : (m_phase == P_RUN) ? '1 : '0;
      return {t, b, d, e, f};
   endfunction

   // Advance the reference model by one clock edge
   task automatic model_step(input logic rst, input logic abort, input logic start);
      if (rst) begin
         m_phase = P_IDLE; m_run = 0; m_stag = 0; m_sleep = 0; m_addr = '0;
      end else if (abort) begin
         if (m_phase == P_STAG || m_phase == P_RUN) m_run++;
         m_phase = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE, P_DONE, P_ERR: begin
               if (start) begin
                  m_addr = tb_addr; m_run = 0; m_phase = P_EN;
               end
            end
            P_EN: begin
               m_phase = P_STAG; m_stag = 0;
            end
            P_STAG: begin
               m_run++;
               if (tb_tmo != 0 && m_run >= int'(tb_tmo)) m_phase = P_ERR;
               else if ((NT - 1) * SC <= m_stag) begin
                  m_phase = P_RUN; m_sleep = 0;
               end else m_stag++;
            end
            P_RUN: begin
               m_run++;
               m_sleep = (&tb_sleep) ? m_sleep + 1 : 0;
               if (m_sleep >= SW) m_phase = P_DONE;
               else if (tb_tmo != 0 && m_run >= int'(tb_tmo)) m_phase = P_ERR;
            end
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model, settle
   task automatic tick(input logic rst, input logic abort, input logic start);
      rst_i        = rst;
      abort_i      = abort;
      start_i      = start;
      boot_addr_i  = tb_addr;
      timeout_i    = tb_tmo;
      core_sleep_i = tb_sleep;
      @(posedge clk_i);
      model_step(rst, abort, start);
      #1;
   endtask

   task automatic test_reset();
      tb_addr = 32'hDEAD_BEEF; tb_tmo = 0; tb_sleep = '1;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (w_status !== 8'h00) $display("FAIL reset_status: got %b expected %b", w_status, 8'h00);
      else n_pass++;
      n_checks++;
      if (boot_addr_o !== 32'h0 || run_cycles_o !== 32'h0)
         $display("FAIL reset_regs: got addr=%h run=%0d expected 0/0", boot_addr_o, run_cycles_o);
      else n_pass++;
      $display("test_reset: status=%b", w_status);
   endtask

   task automatic test_nominal();
      logic [NT-1:0] exp_f;
      tb_addr = 32'h1C00_0080; tb_tmo = 0; tb_sleep = '0;
      tick(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (w_status !== 8'b1100_0000) $display("FAIL nominal_enable: got %b expected %b", w_status, 8'b1100_0000);
      else n_pass++;
      for (int c = 0; c <= 6; c++) begin
         tick(1'b0, 1'b0, 1'b0);
         exp_f = (c >= 6) ? 4'b1111 : (c >= 4) ? 4'b0111 : (c >= 2) ? 4'b0011 : 4'b0001;
         n_checks++;
         if (fetch_enable_o !== exp_f || busy_o !== 1'b1)
            $display("FAIL nominal_stagger_c%0d: got fetch=%b busy=%b expected fetch=%b busy=1", c, fetch_enable_o, busy_o, exp_f);
         else n_pass++;
      end
      tick(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (fetch_enable_o !== 4'b1111 || run_cycles_o !== 32'd7)
         $display("FAIL nominal_run_entry: got fetch=%b run=%0d expected 1111/7", fetch_enable_o, run_cycles_o);
      else n_pass++;
      tb_sleep = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0);
         n_checks++;
         if (done_o !== (i == 2)) $display("FAIL nominal_sleep%0d: got done=%b expected %b", i, done_o, (i == 2));
         else n_pass++;
      end
      n_checks++;
      if (w_status !== 8'b1010_0000 || boot_addr_o !== 32'h1C00_0080 || run_cycles_o !== 32'd10)
         $display("FAIL nominal_done: got status=%b addr=%h run=%0d expected 10100000/1c000080/10", w_status, boot_addr_o, run_cycles_o);
      else n_pass++;
      $display("test_nominal: done=%b run_cycles=%0d", done_o, run_cycles_o);
   endtask

   task automatic test_glitch();
      logic [NT-1:0] seq [6] = '{4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
      tb_addr = 32'h2000_0100; tb_tmo = 0; tb_sleep = '0;
      tick(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (done_o !== 1'b0 || timeout_o !== 1'b0 || run_cycles_o !== 32'd0 || busy_o !== 1'b1)
         $display("FAIL restart_from_done: got done=%b tmo=%b run=%0d busy=%b expected 0/0/0/1", done_o, timeout_o, run_cycles_o, busy_o);
      else n_pass++;
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tb_sleep = seq[i];
         tick(1'b0, 1'b0, 1'b0);
         n_checks++;
         if (done_o !== (i == 5)) $display("FAIL glitch_step%0d: got done=%b expected %b", i, done_o, (i == 5));
         else n_pass++;
      end
      $display("test_glitch: done=%b run_cycles=%0d", done_o, run_cycles_o);
   endtask

   task automatic test_timeout();
      int n;
      tb_addr = 32'h3000_0000; tb_tmo = 32'd20; tb_sleep = '0;
      tick(1'b0, 1'b0, 1'b1);
      n = 0;
      while (timeout_o !== 1'b1 && n < 40) begin
         tick(1'b0, 1'b0, 1'b0);
         n++;
      end
      n_checks++;
      if (timeout_o !== 1'b1 || run_cycles_o !== 32'd20 || w_status !== 8'b0001_0000)
         $display("FAIL timeout_fire: got status=%b run=%0d expected 00010000/20", w_status, run_cycles_o);
      else n_pass++;
      // Completion and timeout land on the same edge (run count 10)
      tb_tmo = 32'd10; tb_sleep = '1;
      tick(1'b0, 1'b0, 1'b1);
      n = 0;
      while (done_o !== 1'b1 && timeout_o !== 1'b1 && n < 40) begin
         tick(1'b0, 1'b0, 1'b0);
         n++;
      end
      n_checks++;
      if (done_o !== 1'b1 || timeout_o !== 1'b0 || run_cycles_o !== 32'd10)
         $display("FAIL timeout_tie: got done=%b tmo=%b run=%0d expected 1/0/10", done_o, timeout_o, run_cycles_o);
      else n_pass++;
      $display("test_timeout: done=%b timeout=%b", done_o, timeout_o);
   endtask

   task automatic test_abort();
      tb_addr = 32'h4000_0040; tb_tmo = 0; tb_sleep = '0;
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (fetch_enable_o !== 4'b0011) $display("FAIL abort_pre: got fetch=%b expected 0011", fetch_enable_o);
      else n_pass++;
      tb_addr = 32'h5555_AAAA;
      tick(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (w_status !== 8'h00 || boot_addr_o !== 32'h4000_0040)
         $display("FAIL abort_idle: got status=%b addr=%h expected 00000000/40000040", w_status, boot_addr_o);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (w_status !== 8'h00) $display("FAIL abort_start_ignored: got status=%b expected 00000000", w_status);
      else n_pass++;
      $display("test_abort: status=%b", w_status);
   endtask

   task automatic test_run_ctrl();
      tb_addr = 32'h6000_0600; tb_tmo = 0; tb_sleep = '0;
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0);
      tb_addr = 32'h7777_0000;
      tick(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (w_status !== 8'b1100_1111 || boot_addr_o !== 32'h6000_0600 || run_cycles_o !== 32'd8)
         $display("FAIL run_start_ignored: got status=%b addr=%h run=%0d expected 11001111/60000600/8", w_status, boot_addr_o, run_cycles_o);
      else n_pass++;
      tick(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (w_status !== 8'h00 || boot_addr_o !== 32'h0 || run_cycles_o !== 32'h0)
         $display("FAIL run_reset: got status=%b addr=%h run=%0d expected all 0", w_status, boot_addr_o, run_cycles_o);
      else n_pass++;
      $display("test_run_ctrl: status=%b", w_status);
   endtask

   task automatic test_random();
      logic rst, abort, start;
      int   bad;
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         abort = ($urandom_range(0, 39) == 0);
         start = ($urandom_range(0, 5) == 0);
         tb_addr = $urandom;
         if (start) tb_tmo = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(8, 30));
         tb_sleep = ($urandom_range(0, 3) != 0) ? '1 : NT'($urandom);
         tick(rst, abort, start);
         n_checks++;
         if (w_status !== exp_status()) begin
            $display("FAIL random_status@%0d: got %b expected %b", i, w_status, exp_status());
            bad++;
         end else n_pass++;
         n_checks++;
         if (run_cycles_o !== 32'(m_run)) begin
            $display("FAIL random_run@%0d: got %0d expected %0d", i, run_cycles_o, m_run);
            bad++;
         end else n_pass++;
         n_checks++;
         if (boot_addr_o !== m_addr) begin
            $display("FAIL random_addr@%0d: got %h expected %h", i, boot_addr_o, m_addr);
            bad++;
         end else n_pass++;
      end
      $display("test_random: 3000 cycles, %0d discrepancies", bad);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_timeout();
      test_abort();
      test_run_ctrl();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
